// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - byte-stream program loader that fills instruction memory and releases the core
module mips_boot_loader #(
    parameter int ADDR_W         = 10,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_STRETCH,
        S_RUN,
        S_ERROR
    } state_t;

    // Word counts are held 17 bits wide so a full 2**ADDR_W image never aliases to zero.
    localparam logic [16:0] CAPACITY    = 17'(64'd1 << ADDR_W);
    localparam logic [7:0]  RELEASE_CNT = 8'(RELEASE_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [7:0]  n_lo;
    logic [16:0] n_words;
    logic [16:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
    logic [7:0]  csum;
    logic [7:0]  rel_cnt;

    logic        xfer;
    logic [16:0] hdr_n;
    logic        last_byte_of_word;

    logic        rx_ready_nxt;
    logic        imem_we_nxt;
    logic        core_reset_nxt;
    logic        done_nxt;
    logic        error_nxt;

    assign xfer              = rx_valid && rx_ready;
    assign hdr_n             = {1'b0, rx_data, n_lo};
    assign last_byte_of_word = (byte_cnt == 2'd3);

    // State register; control outputs are registered alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_HDR0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= next_state;
            rx_ready   <= rx_ready_nxt;
            imem_we    <= imem_we_nxt;
            core_reset <= core_reset_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HDR0: begin
                if (xfer) next_state = S_HDR1;
            end
            S_HDR1: begin
                if (xfer) begin
                    if (hdr_n > CAPACITY)    next_state = S_ERROR;
                    else if (hdr_n == 17'd0) next_state = S_CSUM;
                    else                     next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && last_byte_of_word && (word_idx + 17'd1 == n_words))
                    next_state = S_CSUM;
            end
            S_CSUM: begin
                if (xfer) next_state = (rx_data == csum) ? S_STRETCH : S_ERROR;
            end
            S_STRETCH: begin
                // The decrement that would take the counter to zero is the release edge.
                if (rel_cnt <= 8'd1) next_state = S_RUN;
            end
            S_RUN:   next_state = S_RUN;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_ERROR;
        endcase
    end

    always_comb begin
        rx_ready_nxt   = 1'b0;
        imem_we_nxt    = 1'b0;
        core_reset_nxt = 1'b1;
        done_nxt       = 1'b0;
        error_nxt      = 1'b0;
        case (next_state)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: rx_ready_nxt = 1'b1;
            S_RUN: begin
                core_reset_nxt = 1'b0;
                done_nxt       = 1'b1;
            end
            S_ERROR: error_nxt = 1'b1;
            default: ;
        endcase
        if (state == S_DATA && xfer && last_byte_of_word)
            imem_we_nxt = 1'b1;
    end

    // Datapath: header latch, word assembly, checksum and release counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_lo       <= 8'd0;
            n_words    <= 17'd0;
            word_idx   <= 17'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            csum       <= 8'd0;
            rel_cnt    <= 8'd0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            case (state)
                S_HDR0: if (xfer) n_lo <= rx_data;
                S_HDR1: if (xfer) n_words <= hdr_n;
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        csum     <= csum ^ rx_data;
                        asm_word <= {rx_data, asm_word[23:8]};
                        if (last_byte_of_word) begin
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= {rx_data, asm_word};
                            word_idx   <= word_idx + 17'd1;
                        end
                    end
                end
                S_CSUM:    if (xfer) rel_cnt <= RELEASE_CNT;
                S_STRETCH: rel_cnt <= rel_cnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// tb/tb_mips_boot_loader.sv - randomized self-checking bench for mips_boot_loader
module tb_mips_boot_loader;

    localparam int ADDR_W = 2;
    localparam int REL    = 2;
    localparam int CAP    = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    mips_boot_loader #(.ADDR_W(ADDR_W), .RELEASE_CYCLES(REL)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          got_addr[$];
    logic [31:0] got_data[$];
    int          we_run = 0;
    int          we_max = 0;

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(int'(imem_addr));
            got_data.push_back(imem_wdata);
            we_run++;
            if (we_run > we_max) we_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    task automatic do_reset(input bit check_state);
        @(negedge clock);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clock);
        if (check_state) begin
            check_eq("rst_rx_ready", rx_ready, 0);
            check_eq("rst_imem_we", imem_we, 0);
            check_eq("rst_imem_addr", imem_addr, 0);
            check_eq("rst_imem_wdata", imem_wdata, 0);
            check_eq("rst_core_reset", core_reset, 1);
            check_eq("rst_done", done, 0);
            check_eq("rst_error", error, 0);
        end
        reset = 1'b0;
        @(posedge clock);
        got_addr.delete();
        got_data.delete();
        we_max = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
        int gap;
        bit rdy;
        bit ok;
        gap = (gmax > gmin) ? $urandom_range(gmin, gmax) : gmin;
        repeat (gap) begin
            @(negedge clock);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            rdy = rx_ready;
            @(posedge clock);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check_eq("handshake_timeout", ok, 1);
    endtask

    // Reference: the frame is header + little-endian words + XOR of payload bytes;
    // the load succeeds only if N fits memory and the trailing byte equals that XOR.
    task automatic run_frame(input logic [15:0] n, input logic [31:0] words[$],
                             input int csum_override, input int gmin, input int gmax);
        logic [7:0] payload[$];
        logic [7:0] xsum;
        logic [7:0] cbyte;
        bit         oversize;
        bit         good;
        int         exp_writes;
        oversize = (int'(n) > CAP);
        xsum = 8'd0;
        if (!oversize) begin
            for (int w = 0; w < int'(n); w++)
                for (int k = 0; k < 4; k++) begin
                    payload.push_back(8'((words[w] >> (8 * k)) & 32'hFF));
                    xsum ^= 8'((words[w] >> (8 * k)) & 32'hFF);
                end
        end
        cbyte = (csum_override < 0) ? xsum : 8'(csum_override);
        good  = !oversize && (cbyte == xsum);
        exp_writes = oversize ? 0 : int'(n);

        send_byte(n[7:0], gmin, gmax);
        send_byte(n[15:8], gmin, gmax);
        if (!oversize) begin
            foreach (payload[i]) send_byte(payload[i], gmin, gmax);
            send_byte(cbyte, gmin, gmax);
        end
        @(negedge clock);
        rx_valid = 1'b0;
        if (good) begin
            for (int i = 0; i < REL; i++) begin
                if (i > 0) @(negedge clock);
                check_eq($sformatf("stretch_core_reset_%0d", i), core_reset, 1);
                check_eq($sformatf("stretch_done_%0d", i), done, 0);
            end
            @(negedge clock);
            check_eq("release_core_reset", core_reset, 0);
            check_eq("release_done", done, 1);
        end else begin
            check_eq("err_error", error, 1);
            check_eq("err_core_reset", core_reset, 1);
            check_eq("err_done", done, 0);
        end
        check_eq("term_rx_ready", rx_ready, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clock);
            check_eq("term_hold_rx_ready", rx_ready, 0);
            check_eq("term_hold_done", done, good);
            check_eq("term_hold_error", error, !good);
            check_eq("term_hold_core_reset", core_reset, !good);
        end
        rx_valid = 1'b0;
        repeat (2) @(negedge clock);

        check_eq("write_count", got_addr.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < got_addr.size(); i++) begin
            check_eq($sformatf("write_addr_%0d", i), got_addr[i], i);
            check_eq($sformatf("write_data_%0d", i), got_data[i], words[i]);
        end
        check_eq("we_single_cycle", we_max > 1, 0);
    endtask

    logic [31:0] wq[$];
    logic [31:0] none[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b1);

        wq = '{32'h12345678, 32'hDEADBEEF};
        run_frame(16'd2, wq, -1, 0, 0);

        do_reset(1'b0);
        run_frame(16'd2, wq, -1, 1, 1);

        do_reset(1'b0);
        run_frame(16'd2, wq, 0, 0, 0);

        do_reset(1'b0);
        run_frame(16'd0, none, -1, 0, 1);

        do_reset(1'b0);
        run_frame(16'd5, none, -1, 0, 0);

        do_reset(1'b0);
        run_frame(16'h0100, none, -1, 0, 0);

        do_reset(1'b0);
        wq = '{32'hA5A5A5A5, 32'h00000001, 32'h80000000, 32'hCAFEF00D};
        run_frame(16'(CAP), wq, -1, 0, 2);

        // Abort a two-word load after six payload bytes, then reload cleanly.
        do_reset(1'b0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h78, 0, 0);
        send_byte(8'h56, 0, 0);
        send_byte(8'h34, 0, 0);
        send_byte(8'h12, 0, 0);
        send_byte(8'hEF, 0, 0);
        send_byte(8'hBE, 0, 0);
        do_reset(1'b1);
        wq = '{32'h0BADC0DE, 32'h13579BDF};
        run_frame(16'd2, wq, -1, 0, 1);

        for (int f = 0; f < 20; f++) begin
            int          r;
            logic [15:0] n;
            int          ov;
            r = $urandom_range(0, 9);
            wq.delete();
            if (r < 2) n = 16'($urandom_range(CAP + 1, 65535));
            else       n = 16'($urandom_range(0, CAP));
            if (int'(n) <= CAP)
                for (int w = 0; w < int'(n); w++) wq.push_back($urandom);
            ov = -1;
            if (r == 2 || r == 3) begin
                logic [7:0] x;
                x = 8'd0;
                foreach (wq[i]) x ^= wq[i][7:0] ^ wq[i][15:8] ^ wq[i][23:16] ^ wq[i][31:24];
                ov = int'(x ^ 8'($urandom_range(1, 255)));
            end
            do_reset(1'b0);
            run_frame(n, wq, ov, 0, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
